// File: rtl/minmax_seq_pkg.sv
// Shared FSM state type and default sizing for the sequential min/max frame reducer.
package minmax_pkg;

  localparam int W_DEF    = 8;
  localparam int NI_DEF   = 9;
  localparam int CNTW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

endpackage

// File: rtl/minmax_seq_if.sv
// Beat input / result output handshake bundle for minmax_seq.
// The slave modport is the reducer side, the master modport is the producer/consumer side.
interface minmax_seq_if
  import minmax_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NI   = NI_DEF,
  parameter int CNTW = CNTW_DEF
) ();

  localparam int GIDXW = $clog2(NI * 2**CNTW);

  logic                   in_valid;
  logic                   in_ready;
  logic [NI-1:0][W-1:0]   in_data;
  logic                   in_last;
  logic                   in_sel;
  logic                   out_valid;
  logic                   out_ready;
  logic [W-1:0]           out_value;
  logic [GIDXW-1:0]       out_index;
  logic                   out_ovf;

  modport master (
    output in_valid, in_data, in_last, in_sel, out_ready,
    input  in_ready, out_valid, out_value, out_index, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, in_sel, out_ready,
    output in_ready, out_valid, out_value, out_index, out_ovf
  );

endinterface

// File: rtl/minmax_seq_minmax.sv
// Combinational min/max over one beat of NI elements, returning the winning value and its local index.
// MM_CFG: 0 = runtime select via min_max_sel, 1 = min only, 2 = max only; OUT_CFG: 0 = ties keep lowest index.
module minmax
  import minmax_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int NI      = NI_DEF,
  parameter int OUT_CFG = 0,
  parameter int MM_CFG  = 0
) (
  input  logic [NI-1:0][W-1:0]  in_data,
  input  logic                  min_max_sel,
  output logic [W-1:0]          out_value,
  output logic [$clog2(NI)-1:0] out_index
);

  localparam int IDXW = $clog2(NI);

  logic find_max;

  assign find_max = (MM_CFG == 0) ? min_max_sel : (MM_CFG == 2);

  // Linear scan; a strict compare keeps the earliest element on ties unless OUT_CFG asks otherwise.
  always_comb begin
    out_value = in_data[0];
    out_index = '0;
    for (int k = 1; k < NI; k++) begin
      if (( find_max && (in_data[k] > out_value)) ||
          (!find_max && (in_data[k] < out_value)) ||
          ((OUT_CFG != 0) && (in_data[k] == out_value))) begin
        out_value = in_data[k];
        out_index = IDXW'(k);
      end
    end
  end

endmodule

// File: rtl/minmax_seq.sv
// Frame-level min/max search over multi-beat input, reporting the winning value and its global index.
// Define MINMAX_SEQ_OVF_EN to saturate the beat count and flag frames longer than 2**CNTW beats.
module minmax_seq
  import minmax_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int NI   = NI_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  minmax_seq_if.slave   bus
);

  localparam int IDXW  = $clog2(NI);
  localparam int GIDXW = $clog2(NI * 2**CNTW);

`ifdef MINMAX_SEQ_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  state_t            state;
  state_t            state_nx;
  logic              sel;
  logic [CNTW:0]     cnt;
  logic [CNTW:0]     cnt_next;
  logic [W-1:0]      best;
  logic [GIDXW-1:0]  best_idx;
  logic              ovf;
  logic              cur_sel;
  logic              accept;
  logic              better;
  logic              cnt_full;
  logic [W-1:0]      beat_value;
  logic [IDXW-1:0]   beat_local;
  logic [GIDXW-1:0]  beat_gidx;

  // The first beat of a frame has no latched direction yet, so it uses the live select.
  assign cur_sel = (state == IDLE) ? bus.in_sel : sel;

  minmax #(
    .W       (W),
    .NI      (NI),
    .OUT_CFG (0),
    .MM_CFG  (0)
  ) u_minmax (
    .in_data     (bus.in_data),
    .min_max_sel (cur_sel),
    .out_value   (beat_value),
    .out_index   (beat_local)
  );

  assign accept    = bus.in_valid && bus.in_ready;
  assign beat_gidx = GIDXW'(cnt[CNTW-1:0]) * GIDXW'(NI) + GIDXW'(beat_local);
  assign better    = sel ? (beat_value > best) : (beat_value < best);
  assign cnt_full  = cnt[CNTW];
  assign cnt_next  = OVF_EN ? (cnt + (CNTW+1)'(1)) : {1'b0, cnt[CNTW-1:0] + CNTW'(1)};

  assign bus.out_value = best;
  assign bus.out_index = best_idx;
  assign bus.out_ovf   = OVF_EN ? ovf : 1'b0;

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE, ACC: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nx = bus.in_last ? OUT : ACC;
        end
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Past the beat limit, beats are swallowed without comparison and only the overflow flag moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 1'b0;
      cnt      <= '0;
      best     <= '0;
      best_idx <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        if (state == IDLE) begin
          sel      <= bus.in_sel;
          best     <= beat_value;
          best_idx <= GIDXW'(beat_local);
          cnt      <= (CNTW+1)'(1);
          ovf      <= 1'b0;
        end else if (cnt_full) begin
          ovf <= 1'b1;
        end else begin
          if (better) begin
            best     <= beat_value;
            best_idx <= beat_gidx;
          end
          cnt <= cnt_next;
        end
      end
    end
  end

endmodule
